// File: rtl/tone_arb_pkg.sv
// Shared constants and state encoding for the tone arbiter slice.
// Optional build macro used by this slice: TONE_ARB_FIXED_PRIO_EN.
package tone_arb_pkg;
  localparam int NKEYS  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
endpackage

// File: rtl/rr_pick16.sv
// Combinational picker: first set request bit scanning upward from start,
// wrapping 15 -> 0.
module rr_pick16
  import tone_arb_pkg::*;
(
  input  logic [NKEYS-1:0]  req,
  input  logic [CODE_W-1:0] start,
  output logic              valid,
  output logic [CODE_W-1:0] idx
);
  logic [CODE_W-1:0] k;

  // Walk offsets from far to near so the nearest hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = NKEYS-1; i >= 0; i--) begin
      k = start + CODE_W'(i);
      if (req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end
endmodule

// File: rtl/tone_arbiter.sv
// Time-slicing round-robin arbiter sharing one PWM tone generator among 16 keys.
// Define TONE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr_ptr).
module tone_arbiter
  import tone_arb_pkg::*;
#(
  parameter int SLOT_CYCLES = 4_000_000,
  parameter int GAP_CYCLES  = 200_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  key_req,
  output logic [CODE_W-1:0] pos_t,
  output logic              tone_en,
  output logic [NKEYS-1:0]  grant
);
  localparam int MAXC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SLOT_LD = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] pick_start;
  logic              pick_vld;
  logic [CODE_W-1:0] pick_idx;
  logic              launch;

`ifdef TONE_ARB_FIXED_PRIO_EN
  assign pick_start = '0;
`else
  logic [CODE_W-1:0] rr_ptr;
  assign pick_start = rr_ptr;
`endif

  rr_pick16 u_pick (
    .req   (key_req),
    .start (pick_start),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // A new note starts from IDLE, or once the gap has fully elapsed.
  assign launch = pick_vld && ((state == IDLE) || (state == GAP && cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pos_t   <= '0;
      tone_en <= 1'b0;
      grant   <= '0;
`ifndef TONE_ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else if (launch) begin
      state   <= PLAY;
      cnt     <= SLOT_LD;
      pos_t   <= pick_idx;
      tone_en <= 1'b1;
      grant   <= NKEYS'(1) << pick_idx;
`ifndef TONE_ARB_FIXED_PRIO_EN
      rr_ptr  <= pick_idx + CODE_W'(1);
`endif
    end else begin
      case (state)
        IDLE: begin
          tone_en <= 1'b0;
          grant   <= '0;
        end
        PLAY: begin
          // Release outranks expiry; both paths take the full gap.
          if (!key_req[pos_t]) begin
            state   <= GAP;
            cnt     <= GAP_LD;
            tone_en <= 1'b0;
            grant   <= '0;
          end else if (cnt == '0) begin
            if (key_req == grant) begin
              cnt <= SLOT_LD;
            end else begin
              state   <= GAP;
              cnt     <= GAP_LD;
              tone_en <= 1'b0;
              grant   <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_arbiter.sv
// Directed self-checking bench for tone_arbiter with SLOT_CYCLES=8, GAP_CYCLES=2.
module tb_tone_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_req = '0;
  logic [3:0]  pos_t;
  logic        tone_en;
  logic [15:0] grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tone_arbiter #(.SLOT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_req (key_req),
    .pos_t   (pos_t),
    .tone_en (tone_en),
    .grant   (grant)
  );

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key_req = '0;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (pos_t !== 4'd0 || tone_en !== 1'b0 || grant !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: pos_t=%0d tone_en=%b grant=%h, want 0/0/0000", pos_t, tone_en, grant);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (tone_en !== 1'b0 || grant !== 16'h0) begin
      n_err++;
      $display("FAIL idle_quiet: tone_en=%b grant=%h, want 0/0000", tone_en, grant);
    end
  endtask

  task automatic test_sustain();
    do_reset();
    key_req = 16'h0010;
    tick();
    n_cmp++;
    if (pos_t !== 4'd4 || tone_en !== 1'b1 || grant !== 16'h0010) begin
      n_err++;
      $display("FAIL sustain_start: pos_t=%0d tone_en=%b grant=%h, want 4/1/0010", pos_t, tone_en, grant);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      n_cmp++;
      if (tone_en !== 1'b1 || pos_t !== 4'd4) begin
        n_err++;
        $display("FAIL sustain_hold cyc %0d: pos_t=%0d tone_en=%b, want 4/1", c, pos_t, tone_en);
      end
    end
  endtask

  task automatic test_chord();
    logic [3:0] exp [3];
`ifdef TONE_ARB_FIXED_PRIO_EN
    exp = '{4'd0, 4'd0, 4'd0};
`else
    exp = '{4'd0, 4'd7, 4'd0};
`endif
    do_reset();
    key_req = 16'h0081;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        n_cmp++;
        if (tone_en !== 1'b1 || pos_t !== exp[n] || grant !== (16'h1 << exp[n])) begin
          n_err++;
          $display("FAIL chord_play n%0d c%0d: pos_t=%0d tone_en=%b grant=%h, want %0d/1", n, c, pos_t, tone_en, grant, exp[n]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        n_cmp++;
        if (tone_en !== 1'b0 || grant !== 16'h0 || pos_t !== exp[n]) begin
          n_err++;
          $display("FAIL chord_gap n%0d c%0d: pos_t=%0d tone_en=%b grant=%h, want %0d/0/0000", n, c, pos_t, tone_en, grant, exp[n]);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    key_req = 16'h0004;
    tick();
    tick();
    tick();
    n_cmp++;
    if (tone_en !== 1'b1 || pos_t !== 4'd2) begin
      n_err++;
      $display("FAIL release_play: pos_t=%0d tone_en=%b, want 2/1", pos_t, tone_en);
    end
    key_req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (tone_en !== 1'b0 || grant !== 16'h0 || pos_t !== 4'd2) begin
        n_err++;
        $display("FAIL release_gap c%0d: pos_t=%0d tone_en=%b grant=%h, want 2/0/0000", c, pos_t, tone_en, grant);
      end
    end
    tick();
    n_cmp++;
    if (tone_en !== 1'b0 || grant !== 16'h0) begin
      n_err++;
      $display("FAIL release_idle: tone_en=%b grant=%h, want 0/0000", tone_en, grant);
    end
    // Back in IDLE, a new request plays after a single edge.
    key_req = 16'h0020;
    tick();
    n_cmp++;
    if (tone_en !== 1'b1 || pos_t !== 4'd5) begin
      n_err++;
      $display("FAIL release_relaunch: pos_t=%0d tone_en=%b, want 5/1", pos_t, tone_en);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    key_req = 16'h0200;
    tick();
    tick();
    n_cmp++;
    if (pos_t !== 4'd9 || tone_en !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: pos_t=%0d tone_en=%b, want 9/1", pos_t, tone_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (pos_t !== 4'd0 || tone_en !== 1'b0 || grant !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_clear: pos_t=%0d tone_en=%b grant=%h, want 0/0/0000", pos_t, tone_en, grant);
    end
    tick();
    n_cmp++;
    if (pos_t !== 4'd9 || tone_en !== 1'b1 || grant !== 16'h0200) begin
      n_err++;
      $display("FAIL rstmid_restart: pos_t=%0d tone_en=%b grant=%h, want 9/1/0200", pos_t, tone_en, grant);
    end
    // Pointer is 10 now; reset must bring the scan back to index 0.
    rst = 1'b1;
    key_req = 16'h0801;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (pos_t !== 4'd0 || tone_en !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ptr: pos_t=%0d tone_en=%b, want 0/1", pos_t, tone_en);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp [3];
`ifdef TONE_ARB_FIXED_PRIO_EN
    exp = '{4'd1, 4'd1, 4'd1};
`else
    exp = '{4'd15, 4'd1, 4'd15};
`endif
    do_reset();
    key_req = 16'h4000;
    tick();
    n_cmp++;
    if (pos_t !== 4'd14 || tone_en !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_seed: pos_t=%0d tone_en=%b, want 14/1", pos_t, tone_en);
    end
    key_req = 16'h8002;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (tone_en !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_gap0 c%0d: tone_en=%b, want 0", c, tone_en);
      end
    end
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        n_cmp++;
        if (tone_en !== 1'b1 || pos_t !== exp[n]) begin
          n_err++;
          $display("FAIL wrap_play n%0d c%0d: pos_t=%0d tone_en=%b, want %0d/1", n, c, pos_t, tone_en, exp[n]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        n_cmp++;
        if (tone_en !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_gap n%0d c%0d: tone_en=%b, want 0", n, c, tone_en);
        end
      end
    end
  endtask

  task automatic test_release_at_expiry();
    do_reset();
    key_req = 16'h0041;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (tone_en !== 1'b1 || pos_t !== 4'd0) begin
        n_err++;
        $display("FAIL coinc_play c%0d: pos_t=%0d tone_en=%b, want 0/1", c, pos_t, tone_en);
      end
    end
    // Counter is 0 here; drop key 0 on the same edge the slice expires.
    key_req = 16'h0040;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (tone_en !== 1'b0 || grant !== 16'h0) begin
        n_err++;
        $display("FAIL coinc_gap c%0d: tone_en=%b grant=%h, want 0/0000", c, tone_en, grant);
      end
    end
    tick();
    n_cmp++;
    if (tone_en !== 1'b1 || pos_t !== 4'd6 || grant !== 16'h0040) begin
      n_err++;
      $display("FAIL coinc_next: pos_t=%0d tone_en=%b grant=%h, want 6/1/0040", pos_t, tone_en, grant);
    end
  endtask

  initial begin
    test_reset();
    test_sustain();
    test_chord();
    test_early_release();
    test_reset_mid_play();
    test_wrap();
    test_release_at_expiry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Sequencer that shares the single sine-PWM tone generator among 16 key requests. It arbitrates simultaneously held keys round-robin and time-slices them, so chords play as a fast arpeggio. It drives the generator's 4-bit tone-select code and a tone enable that gates the PWM output. It sits between the debounced keypad scanner and the PWM tone generator.

## Interface
- SLOT_CYCLES, default 4_000_000: clock cycles a granted key plays per slice; legal range ≥ 1.
- GAP_CYCLES, default 200_000: silent clock cycles between two different notes; legal range ≥ 1.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- key_req  in  16  level requests, already debounced and synchronous to clk; bit i requests tone code i.
- pos_t  out  4  tone-select code to the PWM generator; equals the index of the granted key.
- tone_en  out  1  high while a note plays; the top level ANDs it with the PWM output.
- grant  out  16  one-hot granted key during PLAY; all zero otherwise.

## Operation
- Outputs are registered. Reset values: pos_t=0, tone_en=0, grant=0, state=IDLE, rr_ptr=0, counter=0.
- Pick rule:
  - Choose the first set bit of key_req, scanning upward from rr_ptr with wrap 15→0.
  - After every new grant, rr_ptr becomes (granted index + 1) mod 16.
- States:
  - IDLE: tone_en=0.
    - If key_req≠0: pick, load counter=SLOT_CYCLES-1, go to PLAY.
  - PLAY: tone_en=1, pos_t=granted index, grant=one-hot of that index.
    - If the granted key's bit drops before the slice ends: counter=GAP_CYCLES-1, go to GAP. This is an early release.
    - If counter==0 and the granted key is the only bit set: reload counter=SLOT_CYCLES-1 and stay in PLAY. This is sustain: no gap, no pointer change.
    - If counter==0 and another key is set: go to GAP.
    - Otherwise decrement the counter.
  - GAP: tone_en=0, grant=0, pos_t holds its last value.
    - If counter==0: when key_req≠0, pick, load SLOT_CYCLES-1, go to PLAY; else go to IDLE.
    - Otherwise decrement.
- Release takes priority over slice expiry when both occur in the same cycle.
- key_req changes during GAP do not shorten the gap.
- rst asserted mid-PLAY or mid-GAP returns every register to its reset value on the next edge.
- Counter width is $clog2(max(SLOT_CYCLES, GAP_CYCLES)+1). The counter is unsigned and never underflows.

## Timing
- key_req rising from all-zero in IDLE, sampled at edge k: tone_en=1 and pos_t valid after edge k. Latency is 1 cycle.
- A held key that faces competition plays for exactly SLOT_CYCLES cycles with tone_en=1.
- Between different notes there are exactly GAP_CYCLES cycles with tone_en=0.
- An early release is seen at edge k; tone_en=0 after edge k.
- pos_t changes only on the same edge where tone_en rises. It is never changed while tone_en=1.

## Configuration
- Macro: TONE_ARB_FIXED_PRIO_EN.
- Defined: the pick always starts the scan at index 0, so the lowest key wins. rr_ptr is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- Package tone_arb_pkg holds:
  - NKEYS=16 and the code width 4;
  - the state enum {IDLE, PLAY, GAP}.
- Sub-module rr_pick16: combinational picker taking a 16-bit request and a 4-bit start pointer, returning valid plus a 4-bit index. With TONE_ARB_FIXED_PRIO_EN the start pointer is tied to 0.

## Test plan
All scenarios use SLOT_CYCLES=8 and GAP_CYCLES=2.
1. Reset, then key_req=16'h0010 held → after 1 cycle pos_t=4 and tone_en=1; tone_en stays 1 continuously (sustain) with no gap for ≥40 cycles.
2. key_req=16'h0081 from IDLE → pos_t=0 for 8 cycles, 2 cycles tone_en=0, pos_t=7 for 8 cycles, gap, pos_t=0 again. Under TONE_ARB_FIXED_PRIO_EN, pos_t=0 repeats every time.
3. key_req=16'h0004 for 3 cycles, then 0 → tone_en falls 1 cycle after release, 2 gap cycles, then IDLE with grant=0.
4. rst pulsed for 1 cycle during PLAY with pos_t=9 → next cycle pos_t=0, tone_en=0, grant=0; with key_req unchanged, PLAY restarts from index 0's scan.
5. Wrap-around: rr_ptr=15 and key_req=16'h8002 → key 15 granted, then key 1, then key 15.
6. Release and slice expiry in the same cycle → GAP entered, 2 silent cycles, tone_en never glitches high.
